// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and ALU-side signals for the shared ALU arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU environment.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;

    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
        output req_ready,
        output rsp_valid, rsp_result, rsp_zero,
        input  rsp_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero
    );

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_zero,
        output rsp_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands out and a registered result back; one op in flight.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam logic [3:0] CTRL_DEFAULT = 4'b1111;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rr_ptr;
    logic             owner;
    logic             grant;
    logic             grant_valid;
    logic             accept;
    logic             rsp_done;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_ctrl_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;

    // The pointer side wins a tie; otherwise whichever side is asking.
    always_comb begin
        grant       = rr_ptr;
        grant_valid = 1'b0;
        if (bus.req_valid[rr_ptr]) begin
            grant       = rr_ptr;
            grant_valid = 1'b1;
        end else if (bus.req_valid[!rr_ptr]) begin
            grant       = !rr_ptr;
            grant_valid = 1'b1;
        end
    end

    assign sel_a  = grant ? bus.req_a1  : bus.req_a0;
    assign sel_b  = grant ? bus.req_b1  : bus.req_b0;
    assign sel_op = grant ? bus.req_op1 : bus.req_op0;

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                // Gating with rst_n keeps req_ready low while reset is held.
                if (grant_valid && rst_n) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (bus.rsp_ready[owner]) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= RR_INIT;
            owner        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= CTRL_DEFAULT;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q    <= sel_a;
                alu_b_q    <= sel_b;
                alu_ctrl_q <= sel_op;
                owner      <= grant;
            end
            if (state == EXEC) begin
                // A SUB used as a compare reports equality and a zero result.
                if (alu_ctrl_q == CTRL_SUB) begin
                    rsp_zero_q   <= bus.alu_zero;
                    rsp_result_q <= bus.alu_zero ? '0 : bus.alu_result;
                end else begin
                    rsp_zero_q   <= 1'b0;
                    rsp_result_q <= bus.alu_result;
                end
                alu_ctrl_q <= CTRL_DEFAULT;
            end
            if (rsp_done) begin
                rr_ptr <= !owner;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;

    rsp_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
    req_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a transaction-level model is checked
// against the DUT every cycle, alongside hand-computed literal expectations.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_BAD = 4'b1010;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in for the shared ALU; unknown codes give zero.
    always_comb begin
        case (bus.alu_ctrl)
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_result == '0);

    // Expected {zero, result} of a completed operation.
    function automatic logic [WIDTH:0] spec_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return (a == b) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, a - b};
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] spec_grant(input logic [1:0] valid, input logic prio);
        if (valid[prio]) return prio ? 2'b10 : 2'b01;
        if (valid[!prio]) return prio ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    logic             m_busy;
    int               m_age;
    logic             m_owner;
    logic             m_prio;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [3:0]       m_op;
    logic [WIDTH-1:0] m_res;
    logic             m_zero;
    logic [1:0]       m_grant;

    assign m_grant = spec_grant(bus.req_valid, m_prio);

    // Transaction model: cycles since accept decide what the outputs must show.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_owner <= 1'b0;
            m_prio  <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_op    <= 4'b1111;
            m_res   <= '0;
            m_zero  <= 1'b0;
        end else if (!m_busy) begin
            if (m_grant != 2'b00) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_owner <= m_grant[1];
                m_a     <= m_grant[1] ? bus.req_a1  : bus.req_a0;
                m_b     <= m_grant[1] ? bus.req_b1  : bus.req_b0;
                m_op    <= m_grant[1] ? bus.req_op1 : bus.req_op0;
            end
        end else if (m_age == 1) begin
            {m_zero, m_res} <= spec_op(m_op, m_a, m_b);
            m_age <= 2;
        end else if (bus.rsp_ready[m_owner]) begin
            m_busy <= 1'b0;
            m_prio <= !m_owner;
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] exp_ready;
        logic [1:0] exp_rspv;
        logic [3:0] exp_ctrl;
        exp_ready = (!rst_n || m_busy) ? 2'b00 : m_grant;
        exp_rspv  = (rst_n && m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        exp_ctrl  = (rst_n && m_busy && m_age == 1) ? m_op : 4'b1111;
        checkOutput("cyc_req_ready", WIDTH'(bus.req_ready), WIDTH'(exp_ready));
        checkOutput("cyc_rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(exp_rspv));
        checkOutput("cyc_alu_ctrl", WIDTH'(bus.alu_ctrl), WIDTH'(exp_ctrl));
        checkOutput("cyc_alu_a", bus.alu_a, m_a);
        checkOutput("cyc_alu_b", bus.alu_b, m_b);
        checkOutput("cyc_rsp_result", bus.rsp_result, m_res);
        checkOutput("cyc_rsp_zero", WIDTH'(bus.rsp_zero), WIDTH'(m_zero));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [3:0] op0,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic [3:0] op1);
        bus.req_valid = valid;
        bus.req_a0    = a0;
        bus.req_b0    = b0;
        bus.req_op0   = op0;
        bus.req_a1    = a1;
        bus.req_b1    = b1;
        bus.req_op1   = op1;
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    // One complete transaction from a single requester with the response taken at once.
    task automatic runOp(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] op, input logic [WIDTH-1:0] exp_res,
                         input logic exp_zero, input string name);
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        if (idx == 0) applyStimulus(oh, a, b, op, '0, '0, OP_AND);
        else          applyStimulus(oh, '0, '0, OP_AND, a, b, op);
        bus.rsp_ready = 2'b11;
        #1 checkOutput({name, "_ready"}, WIDTH'(bus.req_ready), WIDTH'(oh));
        step();
        bus.req_valid = 2'b00;
        checkOutput({name, "_ctrl"}, WIDTH'(bus.alu_ctrl), WIDTH'(op));
        step();
        checkOutput({name, "_rspv"}, WIDTH'(bus.rsp_valid), WIDTH'(oh));
        checkOutput({name, "_result"}, bus.rsp_result, exp_res);
        checkOutput({name, "_zero"}, WIDTH'(bus.rsp_zero), WIDTH'(exp_zero));
        step();
        checkOutput({name, "_done"}, WIDTH'(bus.rsp_valid), WIDTH'(2'b00));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(2'b00, '0, '0, OP_AND, '0, '0, OP_AND);
        doReset();
        checkOutput("reset_ctrl", WIDTH'(bus.alu_ctrl), WIDTH'(4'b1111));
        checkOutput("reset_result", bus.rsp_result, '0);

        // Single ADD, then SUB compare (equal and unequal), then an unsupported code.
        runOp(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, "t1_add");
        runOp(1, 32'h1234, 32'h1234, OP_SUB, 32'd0, 1'b1, "t3_sub_eq");
        runOp(1, 32'd10, 32'd3, OP_SUB, 32'd7, 1'b0, "t3_sub_ne");
        runOp(0, 32'hDEAD, 32'hBEEF, OP_BAD, 32'd0, 1'b0, "t5_bad");

        // Simultaneous requests straight out of reset: requester 0 first, then 1.
        doReset();
        applyStimulus(2'b11, 32'hF0F0, 32'h0FF0, OP_AND, 32'h000F, 32'h00F0, OP_OR);
        bus.rsp_ready = 2'b11;
        #1 checkOutput("t2_first_grant", WIDTH'(bus.req_ready), WIDTH'(2'b01));
        step();
        bus.req_valid = 2'b10;
        checkOutput("t2_ctrl0", WIDTH'(bus.alu_ctrl), WIDTH'(OP_AND));
        step();
        checkOutput("t2_rspv0", WIDTH'(bus.rsp_valid), WIDTH'(2'b01));
        checkOutput("t2_result0", bus.rsp_result, 32'h00F0);
        step();
        checkOutput("t2_second_grant", WIDTH'(bus.req_ready), WIDTH'(2'b10));
        step();
        bus.req_valid = 2'b00;
        checkOutput("t2_ctrl1", WIDTH'(bus.alu_ctrl), WIDTH'(OP_OR));
        step();
        checkOutput("t2_rspv1", WIDTH'(bus.rsp_valid), WIDTH'(2'b10));
        checkOutput("t2_result1", bus.rsp_result, 32'h00FF);
        step();
        bus.req_valid = 2'b11;
        #1 checkOutput("t2_prio_back", WIDTH'(bus.req_ready), WIDTH'(2'b01));
        bus.req_valid = 2'b00;
        #1 checkOutput("t2_drop", WIDTH'(bus.req_ready), WIDTH'(2'b00));
        step();
        checkOutput("t2_nothing_latched", WIDTH'(bus.alu_ctrl), WIDTH'(4'b1111));

        // Backpressure with requester 0 still asking; operands change after accept.
        applyStimulus(2'b01, 32'd20, 32'd22, OP_ADD, '0, '0, OP_AND);
        bus.rsp_ready = 2'b00;
        #1 checkOutput("t4_ready", WIDTH'(bus.req_ready), WIDTH'(2'b01));
        step();
        bus.req_a0 = 32'd100;
        bus.req_b0 = 32'd1;
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_rspv", WIDTH'(bus.rsp_valid), WIDTH'(2'b01));
            checkOutput("t4_hold_result", bus.rsp_result, 32'd42);
            checkOutput("t4_hold_ready", WIDTH'(bus.req_ready), WIDTH'(2'b00));
            step();
        end
        bus.rsp_ready = 2'b10;
        step();
        checkOutput("t4_non_owner_ignored", WIDTH'(bus.rsp_valid), WIDTH'(2'b01));
        bus.rsp_ready = 2'b01;
        step();
        checkOutput("t4_next_ready", WIDTH'(bus.req_ready), WIDTH'(2'b01));
        step();
        bus.req_valid = 2'b00;
        step();
        checkOutput("t4_next_result", bus.rsp_result, 32'd101);
        step();

        // Reset while the op is executing: it must vanish without a response.
        applyStimulus(2'b01, 32'd9, 32'd9, OP_ADD, '0, '0, OP_AND);
        bus.rsp_ready = 2'b01;
        step();
        bus.req_valid = 2'b00;
        checkOutput("t6_in_exec", WIDTH'(bus.alu_ctrl), WIDTH'(OP_ADD));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_ctrl", WIDTH'(bus.alu_ctrl), WIDTH'(4'b1111));
        checkOutput("t6_rspv", WIDTH'(bus.rsp_valid), WIDTH'(2'b00));
        checkOutput("t6_alu_a", bus.alu_a, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t6_no_rsp", WIDTH'(bus.rsp_valid), WIDTH'(2'b00));
        end
        runOp(0, 32'hFFFF_FFFF, 32'd2, OP_ADD, 32'd1, 1'b0, "t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
